// File: rtl/inst_stream_loader.sv
// Byte-stream instruction loader: packs big-endian bytes into words and writes them to instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified in the CHECK state.
module inst_stream_loader #(
  parameter int OPCODE_WIDTH = 25,
  parameter int OPCODE_COUNT = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic                              write_inst_en,
  output logic [OPCODE_WIDTH-1:0]           write_inst_data,
  output logic [$clog2(OPCODE_COUNT)-1:0]   write_inst_addr,
  output logic                              mpu_reset,
  output logic                              load_done,
  output logic                              load_error,
  output logic [$clog2(OPCODE_COUNT):0]     inst_count
);

  localparam int AW = $clog2(OPCODE_COUNT);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERROR} state_t;

  state_t            state, next_state;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sr;
  logic              last_word;
  logic [31:0]       full_word;
  logic              accept;
  logic              start_ok;
  logic              hi_bad;
  logic              overflow;
  logic              go_write;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign full_word = {word_sr, in_data};
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);
  assign hi_bad    = (full_word >> OPCODE_WIDTH) != 32'd0;
  assign overflow  = inst_count == CW'(OPCODE_COUNT);
  assign go_write  = (state == LOAD) && (next_state == WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    in_ready      = 1'b0;
    write_inst_en = 1'b0;
    load_done     = 1'b0;
    load_error    = 1'b0;
    mpu_reset     = reset || !(state == IDLE || state == DONE);
    case (state)
      IDLE, DONE, ERROR: begin
        load_done  = (state == DONE);
        load_error = (state == ERROR);
        if (start) next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept) begin
          if (byte_idx != 2'd3) begin
            if (in_last) next_state = ERROR;
          end else if (hi_bad || overflow) begin
            next_state = ERROR;
          end else begin
            next_state = WRITE;
          end
        end
      end
      WRITE: begin
        write_inst_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        // in_last on the final word's fourth byte announces that the checksum byte follows
        next_state = last_word ? CHECK : LOAD;
`else
        next_state = last_word ? DONE : LOAD;
`endif
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (accept) next_state = (in_last && in_data == csum) ? DONE : ERROR;
`else
        next_state = ERROR;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx        <= '0;
      word_sr         <= '0;
      last_word       <= 1'b0;
      inst_count      <= '0;
      write_inst_data <= '0;
      write_inst_addr <= '0;
    end else begin
      if (start_ok) begin
        byte_idx   <= '0;
        inst_count <= '0;
      end
      if (state == LOAD && accept) begin
        byte_idx <= 2'(byte_idx + 2'd1);
        word_sr  <= {word_sr[15:0], in_data};
      end
      // Address and data only change on a real write so they hold otherwise
      if (go_write) begin
        write_inst_data <= full_word[OPCODE_WIDTH-1:0];
        write_inst_addr <= inst_count[AW-1:0];
        last_word       <= in_last;
      end
      if (state == WRITE) inst_count <= CW'(inst_count + 1'b1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        csum <= '0;
    else if (start_ok)                csum <= '0;
    else if (state == LOAD && accept) csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_inst_stream_loader.sv
// Directed self-checking bench for inst_stream_loader in its default build (no checksum).
module tb_inst_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        write_inst_en;
  logic [24:0] write_inst_data;
  logic [5:0]  write_inst_addr;
  logic        mpu_reset;
  logic        load_done;
  logic        load_error;
  logic [6:0]  inst_count;

  int tests = 0;
  int fails = 0;
  int wr_n  = 0;
  logic [5:0]  log_addr [0:127];
  logic [24:0] log_data [0:127];

  inst_stream_loader #(.OPCODE_WIDTH(25), .OPCODE_COUNT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .write_inst_en(write_inst_en),
    .write_inst_data(write_inst_data), .write_inst_addr(write_inst_addr),
    .mpu_reset(mpu_reset), .load_done(load_done), .load_error(load_error),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_inst_en === 1'b1 && wr_n < 128) begin
      log_addr[wr_n] = write_inst_addr;
      log_data[wr_n] = write_inst_data;
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns #1 after the rising edge on which the byte was accepted
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   l);
  endtask

  initial begin
    int base;
    int bad;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en", {31'd0, write_inst_en}, 32'd0);
    check("rst_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    check("rst_done_err", {30'd0, load_done, load_error}, 32'd0);
    check("rst_count", {25'd0, inst_count}, 32'd0);
    check("rst_wdata", {7'd0, write_inst_data}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("idle_mpu_reset", {31'd0, mpu_reset}, 32'd0);

    // Two-word program, last on the final byte
    pulse_start();
    check("load_in_ready", {31'd0, in_ready}, 32'd1);
    check("load_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    base = wr_n;
    send_word(32'h0000_0001, 1'b0);
    check("w0_strobe", {31'd0, write_inst_en}, 32'd1);
    send_word(32'h01FF_FFFF, 1'b1);
    check("w1_strobe", {31'd0, write_inst_en}, 32'd1);
    check("w1_addr", {26'd0, write_inst_addr}, 32'd1);
    check("w1_data", {7'd0, write_inst_data}, 32'h01FF_FFFF);
    @(posedge clk); #1;
    check("a_writes", wr_n - base, 32'd2);
    check("a_log0", {log_addr[base], log_data[base]}, {6'd0, 25'h000_0001});
    check("a_log1", {log_addr[base+1], log_data[base+1]}, {6'd1, 25'h1FF_FFFF});
    check("a_count", {25'd0, inst_count}, 32'd2);
    check("a_done", {30'd0, load_done, load_error}, 32'd2);
    check("a_mpu_reset", {31'd0, mpu_reset}, 32'd0);
    check("a_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk); #1;
    check("a_hold_wr_en", {31'd0, write_inst_en}, 32'd0);
    check("a_hold_addr", {26'd0, write_inst_addr}, 32'd1);

    // Opcode bits above OPCODE_WIDTH set
    pulse_start();
    check("b_cleared", {23'd0, load_done, load_error, inst_count}, 32'd0);
    base = wr_n;
    send_word(32'h0200_0000, 1'b0);
    check("b_error", {30'd0, load_done, load_error}, 32'd1);
    check("b_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    @(posedge clk); #1;
    check("b_no_write", wr_n - base, 32'd0);
    check("b_hold_data", {7'd0, write_inst_data}, 32'h01FF_FFFF);
    check("b_count", {25'd0, inst_count}, 32'd0);

    // Truncated word: in_last on second byte
    pulse_start();
    send_word(32'h0000_0005, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b1);
    check("c_error", {30'd0, load_done, load_error}, 32'd1);
    check("c_count", {25'd0, inst_count}, 32'd1);

    // start during LOAD must not restart the byte index
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b1);
    @(posedge clk); #1;
    check("d_done", {30'd0, load_done, load_error}, 32'd2);
    check("d_count", {25'd0, inst_count}, 32'd1);
    check("d_data", {7'd0, write_inst_data}, 32'h7);

    // Overflow: 65 words into a 64-deep memory
    pulse_start();
    base = wr_n;
    for (int i = 0; i < 65; i++) send_word(32'(i), i == 64);
    @(posedge clk); #1;
    check("e_writes", wr_n - base, 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (log_addr[base+i] !== 6'(i) || log_data[base+i] !== 25'(i)) bad++;
    check("e_log_bad", bad, 32'd0);
    check("e_error", {30'd0, load_done, load_error}, 32'd1);
    check("e_count", {25'd0, inst_count}, 32'd64);

    // Reset during WRITE with in_valid held high
    pulse_start();
    send_word(32'h0000_0009, 1'b0);
    check("f_in_write", {31'd0, write_inst_en}, 32'd1);
    base = wr_n;
    in_valid = 1'b1; in_data = 8'hAA;
    reset = 1'b1;
    #1;
    check("f_wr_en", {31'd0, write_inst_en}, 32'd0);
    check("f_addr_data", {write_inst_addr, write_inst_data}, 32'd0);
    check("f_ctl", {28'd0, in_ready, mpu_reset, load_done, load_error}, 32'h4);
    check("f_count", {25'd0, inst_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("f_no_write", wr_n - base, 32'd0);
    check("f_idle", {29'd0, in_ready, mpu_reset, write_inst_en}, 32'd0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
